// File: rtl/wts_slot_if.sv
// Request/done handshake and MSX slot bus signals of the slot initiator.
// master = the initiator block, slave = host logic plus slot responder.
interface wts_slot_if;
  logic        req;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        done;
  logic [7:0]  rdata;
  logic        timeout;
  logic        int_req;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic [7:0]  slot_d_in;
  logic        slot_nsltsl;
  logic        slot_nmerq;
  logic        slot_nrd;
  logic        slot_nwr;
  logic        slot_nwait;
  logic        slot_nint;

  modport master (
    input  req, req_wr, req_addr, req_wdata, slot_d_in, slot_nwait, slot_nint,
    output req_ready, done, rdata, timeout, int_req,
    output slot_a, slot_d_out, slot_d_oe, slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, slot_d_in, slot_nwait, slot_nint,
    input  req_ready, done, rdata, timeout, int_req,
    input  slot_a, slot_d_out, slot_d_oe, slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr
  );
endinterface

// File: rtl/wts_slot_master.sv
// MSX slot bus initiator: one request becomes a Z80-style T1/T2/(Tw)*/T3 memory cycle.
// Handshake: a request is taken in any cycle with req=1 and req_ready=1; done pulses once per access.
module wts_slot_master #(
  parameter int TCLK     = 6,
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  wts_slot_if.master  bus,
  output logic [2:0]  dbg_state
);
  localparam int          CW       = $clog2(TCLK);
  localparam logic [CW-1:0] TLAST    = CW'(TCLK - 1);
  localparam logic [CW-1:0] THALF    = CW'(TCLK / 2);
  localparam logic [CW-1:0] THALF_M1 = CW'(TCLK / 2 - 1);
  localparam logic [7:0]  MAXW     = 8'(MAX_WAIT);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          wr_q, wr_d;
  logic          tout_q, tout_d;
  logic          nwait_s1_q, nwait_s1_d, nwait_s2_q, nwait_s2_d;
  logic          nint_s1_q, nint_s1_d, int_req_q, int_req_d;
  logic          req_ready_q, req_ready_d, done_q, done_d, timeout_q, timeout_d;
  logic [7:0]    rdata_q, rdata_d, slot_d_out_q, slot_d_out_d;
  logic [15:0]   slot_a_q, slot_a_d;
  logic          slot_d_oe_q, slot_d_oe_d;
  logic          nsltsl_q, nsltsl_d, nmerq_q, nmerq_d, nrd_q, nrd_d, nwr_q, nwr_d;
  logic          last, accept, bus_act;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    wcnt_d     = wcnt_q;
    wr_d       = wr_q;
    tout_d     = tout_q;
    last       = (tcnt_q == TLAST);
    accept     = (state_q == S_IDLE) && bus.req;
    nwait_s1_d = bus.slot_nwait;
    nwait_s2_d = nwait_s1_q;
    nint_s1_d  = bus.slot_nint;
    int_req_d  = ~nint_s1_q;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (bus.req) begin
          state_d = S_T1;
          wr_d    = bus.req_wr;
        end
      end
      S_T1: begin
        wcnt_d = '0;
        tout_d = 1'b0;
        tcnt_d = last ? '0 : tcnt_q + 1'b1;
        if (last) state_d = S_T2;
      end
      S_T2, S_TW: begin
        tcnt_d = last ? '0 : tcnt_q + 1'b1;
        if (last) begin
          // Wait is sampled once per T-state, on its final clock.
          if (!nwait_s2_q) begin
            if (wcnt_q < MAXW) begin
              state_d = S_TW;
              wcnt_d  = wcnt_q + 8'd1;
            end else begin
              state_d = S_T3;
              tout_d  = 1'b1;
            end
          end else begin
            state_d = S_T3;
          end
        end
      end
      S_T3: begin
        tcnt_d = last ? '0 : tcnt_q + 1'b1;
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the state being entered.
    bus_act      = (state_d == S_T2) || (state_d == S_TW) ||
                   ((state_d == S_T3) && (tcnt_d < THALF));
    req_ready_d  = (state_d == S_IDLE);
    done_d       = (state_d == S_T3) && (tcnt_d == TLAST);
    timeout_d    = done_d ? tout_d : timeout_q;
    slot_a_d     = accept ? bus.req_addr : slot_a_q;
    slot_d_out_d = (accept && bus.req_wr) ? bus.req_wdata : slot_d_out_q;
    slot_d_oe_d  = wr_d && (state_d != S_IDLE);
    nsltsl_d     = ~bus_act;
    nmerq_d      = ~bus_act;
    nrd_d        = ~(bus_act && !wr_d);
    nwr_d        = ~(bus_act && wr_d);
    rdata_d      = rdata_q;
    if ((state_q == S_T3) && (tcnt_q == THALF_M1) && !wr_q) rdata_d = bus.slot_d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tcnt_q       <= '0;
      wcnt_q       <= '0;
      wr_q         <= 1'b0;
      tout_q       <= 1'b0;
      nwait_s1_q   <= 1'b1;
      nwait_s2_q   <= 1'b1;
      nint_s1_q    <= 1'b1;
      int_req_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rdata_q      <= '0;
      slot_a_q     <= '0;
      slot_d_out_q <= '0;
      slot_d_oe_q  <= 1'b0;
      nsltsl_q     <= 1'b1;
      nmerq_q      <= 1'b1;
      nrd_q        <= 1'b1;
      nwr_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      wcnt_q       <= wcnt_d;
      wr_q         <= wr_d;
      tout_q       <= tout_d;
      nwait_s1_q   <= nwait_s1_d;
      nwait_s2_q   <= nwait_s2_d;
      nint_s1_q    <= nint_s1_d;
      int_req_q    <= int_req_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      rdata_q      <= rdata_d;
      slot_a_q     <= slot_a_d;
      slot_d_out_q <= slot_d_out_d;
      slot_d_oe_q  <= slot_d_oe_d;
      nsltsl_q     <= nsltsl_d;
      nmerq_q      <= nmerq_d;
      nrd_q        <= nrd_d;
      nwr_q        <= nwr_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.timeout     = timeout_q;
  assign bus.int_req     = int_req_q;
  assign bus.slot_a      = slot_a_q;
  assign bus.slot_d_out  = slot_d_out_q;
  assign bus.slot_d_oe   = slot_d_oe_q;
  assign bus.slot_nsltsl = nsltsl_q;
  assign bus.slot_nmerq  = nmerq_q;
  assign bus.slot_nrd    = nrd_q;
  assign bus.slot_nwr    = nwr_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_wts_slot_master.sv
// Bench for wts_slot_master: directed table, hand-written reset/interrupt sequences,
// and random accesses whose timing comes from a cycle-arithmetic reference model.
module tb_wts_slot_master;
  localparam int TCLK     = 6;
  localparam int MAX_WAIT = 3;

  // ---------------- clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wts_slot_if bus();
  logic [2:0] dbg_state;

  wts_slot_master #(.TCLK(TCLK), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'h00;
  logic       last_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] flags();
    return {bus.req_ready, bus.done, bus.slot_nsltsl, bus.slot_nmerq,
            bus.slot_nrd, bus.slot_nwr, bus.slot_d_oe};
  endfunction

  // Reference: the wait line is looked at on the last clock of T2 and of each Tw,
  // i.e. at cycle 2*TCLK + TCLK*j, seeing the input as it was two clocks earlier.
  function automatic void model_waits(input int lo_s, input int lo_e,
                                      output int nw, output bit to);
    nw = 0;
    to = 1'b0;
    for (int j = 0; j <= MAX_WAIT; j++) begin
      int c;
      c = 2 * TCLK + TCLK * j - 2;
      if (!(c >= lo_s && c <= lo_e)) return;
      if (j == MAX_WAIT) begin
        to = 1'b1;
        return;
      end
      nw = j + 1;
    end
  endfunction

  // ---------------- driver tasks
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_flags", 32'(flags()), 32'(7'b1011110));
      chk("idle_rdata", 32'(bus.rdata), 32'(last_rd));
      chk("idle_timeout", 32'(bus.timeout), 32'(last_to));
      bus.req        = 1'b0;
      bus.slot_nwait = 1'b1;
      bus.slot_d_in  = 8'($urandom_range(0, 255));
    end
  endtask

  // Cycle 0 is the clock in which the request is taken; checks sample mid-cycle.
  task automatic run_access(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] din, input int lo_s, input int lo_e,
                            input int exp_done, input bit exp_to, input bit hold);
    int         latch_k;
    logic [7:0] new_rd;
    latch_k = exp_done - TCLK / 2;
    if (!wr) exp_q.push_back(din);
    new_rd = wr ? last_rd : exp_q[0];
    for (int k = 0; k <= exp_done; k++) begin
      logic       act;
      logic [6:0] ef;
      @(negedge clk);
      act = (k >= TCLK + 1) && (k <= latch_k);
      ef  = {k == 0, k == exp_done, !act, !act, !(act && !wr), !(act && wr), wr && (k >= 1)};
      chk($sformatf("flags_c%0d", k), 32'(flags()), 32'(ef));
      chk($sformatf("rdata_c%0d", k), 32'(bus.rdata), 32'((k > latch_k) ? new_rd : last_rd));
      chk($sformatf("timeout_c%0d", k), 32'(bus.timeout), 32'((k >= exp_done) ? exp_to : last_to));
      if (k >= 1) chk($sformatf("slot_a_c%0d", k), 32'(bus.slot_a), 32'(addr));
      if (k >= 1 && wr) chk($sformatf("d_out_c%0d", k), 32'(bus.slot_d_out), 32'(wd));
      if (k == 0) begin
        bus.req       = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
      end else begin
        bus.req = hold;
        if (hold) begin
          bus.req_wr    = 1'($urandom_range(0, 1));
          bus.req_addr  = 16'($urandom_range(0, 65535));
          bus.req_wdata = 8'($urandom_range(0, 255));
        end
      end
      bus.slot_d_in  = (k == latch_k) ? din : ~din;
      bus.slot_nwait = !(k >= lo_s && k <= lo_e);
    end
    if (!wr) last_rd = exp_q.pop_front();
    last_to = exp_to;
  endtask

  task automatic int_seq();
    @(negedge clk);
    bus.slot_nint = 1'b0;
    @(negedge clk);
    chk("int_set_early", 32'(bus.int_req), 32'd0);
    repeat (2) @(negedge clk);
    chk("int_set", 32'(bus.int_req), 32'd1);
    bus.slot_nint = 1'b1;
    @(negedge clk);
    chk("int_clr_early", 32'(bus.int_req), 32'd1);
    repeat (2) @(negedge clk);
    chk("int_clr", 32'(bus.int_req), 32'd0);
  endtask

  // ---------------- directed table
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    int          lo_s;
    int          lo_e;
    int          exp_done;
    bit          exp_to;
    bit          hold;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 16'h9800, 8'h5A, 8'h00, 1000, 0,  18, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h9801, 8'h00, 8'hC3, 1000, 0,  18, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'h9802, 8'h00, 8'h3C, 5,    16, 30, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h9803, 8'hA5, 8'h00, 1,    40, 36, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'h9804, 8'h00, 8'h77, 1,    40, 36, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h9805, 8'h00, 8'h11, 1000, 0,  18, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h1234, 8'hE7, 8'h00, 1000, 0,  18, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 16'h4321, 8'h00, 8'h99, 1000, 0,  18, 1'b0, 1'b0};

    bus.req        = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.slot_d_in  = '0;
    bus.slot_nwait = 1'b1;
    bus.slot_nint  = 1'b1;
    reset          = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_flags", 32'(flags()), 32'(7'b1011110));
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_int", 32'(bus.int_req), 32'd0);
    chk("rst_slot_a", 32'(bus.slot_a), 32'd0);
    chk("rst_d_out", 32'(bus.slot_d_out), 32'd0);
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 8; i++) begin
      run_access(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].din, tbl[i].lo_s, tbl[i].lo_e,
                 tbl[i].exp_done, tbl[i].exp_to, tbl[i].hold);
      if (!tbl[i].hold) idle(3);
    end

    // Reset in the middle of T2 of a write.
    @(negedge clk);
    bus.req = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 16'hAAAA; bus.req_wdata = 8'hF0;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_nwr_low", 32'(bus.slot_nwr), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", 32'(flags()), 32'(7'b1011110));
    chk("mid_rst_slot_a", 32'(bus.slot_a), 32'd0);
    chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = 8'h00;
    last_to = 1'b0;
    idle(25);

    // Interrupt synchroniser while an access is in flight.
    fork
      run_access(1'b0, 16'h5555, 8'h00, 8'h6B, 1000, 0, 18, 1'b0, 1'b0);
      int_seq();
    join
    idle(3);

    // Random accesses against the cycle-arithmetic model.
    for (int r = 0; r < 40; r++) begin
      bit          wr, to;
      int          lo_s, len, nw;
      logic [15:0] a;
      logic [7:0]  d;
      wr   = 1'($urandom_range(0, 1));
      a    = 16'($urandom_range(0, 65535));
      d    = 8'($urandom_range(0, 255));
      lo_s = $urandom_range(0, 40);
      len  = $urandom_range(0, 25);
      model_waits(lo_s, lo_s + len - 1, nw, to);
      run_access(wr, a, d, ~d ^ 8'h3C, lo_s, lo_s + len - 1,
                 3 * TCLK + TCLK * nw, to, 1'($urandom_range(0, 3) == 0));
      idle(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
